// File: rtl/graph_draw_engine.sv
// graph_draw_engine: command-driven PLOT / Bresenham LINE / CLEAR pixel writer with 2x screen scaling and clipping
module graph_draw_engine #(
  parameter int GW = 320,
  parameter int GH = 240
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [8:0] cmd_x0,
  input  logic [8:0] cmd_x1,
  input  logic [7:0] cmd_y0,
  input  logic [7:0] cmd_y1,
  input  logic [3:0] cmd_pal,
  output logic       busy,
  output logic       fb_we,
  output logic [9:0] fb_xloc,
  output logic [8:0] fb_yloc,
  output logic [3:0] fb_pal
);
  localparam logic [1:0] IDLE = 2'd0, PLOT = 2'd1, LINE = 2'd2, CLEAR = 2'd3;
  localparam logic [9:0] GW_L = 10'(GW);
  localparam logic [8:0] GH_L = 9'(GH);
  localparam logic [8:0] XL = 9'(GW - 1);
  localparam logic [7:0] YL = 8'(GH - 1);
  logic [1:0] state, nstate;
  logic [8:0] x, nx, xe;
  logic [7:0] y, ny, ye;
  logic [9:0] dx, adx;
  logic [7:0] ady;
  logic signed [9:0] ddx;
  logic signed [8:0] ddy;
  logic signed [11:0] dy, err, err_n;
  logic signed [12:0] e2;
  logic sx, sy, step_x, step_y, go;
  logic [3:0] pal;
  assign cmd_ready = state == IDLE;
  assign busy = !cmd_ready;
  always_comb begin
    ddx = $signed({1'b0, cmd_x1}) - $signed({1'b0, cmd_x0});
    ddy = $signed({1'b0, cmd_y1}) - $signed({1'b0, cmd_y0});
    adx = ddx[9] ? -ddx : ddx;
    ady = ddy[8] ? 8'(-ddy) : 8'(ddy);
    e2 = $signed({err, 1'b0});
    step_x = e2 >= $signed({dy[11], dy});
    step_y = e2 <= $signed({3'b0, dx});
    err_n = err + (step_x ? dy : 12'sd0) + (step_y ? $signed({2'b0, dx}) : 12'sd0);
    nstate = state;
    nx = x;
    ny = y;
    go = 1'b0;
    case (state)
      IDLE: if (cmd_valid) begin
        go = cmd_op != 2'd3;
        nx = cmd_op == 2'd2 ? 9'd0 : cmd_x0;
        ny = cmd_op == 2'd2 ? 8'd0 : cmd_y0;
        nstate = cmd_op == 2'd1 ? LINE : cmd_op == 2'd2 ? CLEAR : PLOT;
      end
      PLOT: nstate = IDLE;
      LINE: if (x == xe && y == ye) nstate = IDLE;
      else begin
        go = 1'b1;
        nx = step_x ? (sx ? x - 9'd1 : x + 9'd1) : x;
        ny = step_y ? (sy ? y - 8'd1 : y + 8'd1) : y;
      end
      default: if (x == XL && y == YL) nstate = IDLE;
      else begin
        go = 1'b1;
        nx = x == XL ? 9'd0 : x + 9'd1;
        ny = x == XL ? y + 8'd1 : y;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fb_we <= 1'b0;
      fb_xloc <= '0;
      fb_yloc <= '0;
      fb_pal <= '0;
    end else begin
      state <= nstate;
      x <= nx;
      y <= ny;
      fb_we <= go && {1'b0, nx} < GW_L && {1'b0, ny} < GH_L;
      if (go) begin
        fb_xloc <= {nx, 1'b0};
        fb_yloc <= {ny, 1'b0};
        fb_pal <= state == IDLE ? cmd_pal : pal;
      end
      // Bresenham setup: dx positive, dy negative magnitude, err = dx + dy
      if (state == IDLE && cmd_valid) begin
        pal <= cmd_pal;
        xe <= cmd_x1;
        ye <= cmd_y1;
        dx <= adx;
        dy <= -$signed({4'b0, ady});
        sx <= ddx[9];
        sy <= ddy[8];
        err <= $signed({2'b0, adx}) - $signed({4'b0, ady});
      end else if (state == LINE) err <= err_n;
    end
  end
endmodule

// File: tb/tb_graph_draw_engine.sv
// tb_graph_draw_engine: directed and random commands checked cycle-by-cycle against a pixel-list model
module tb_graph_draw_engine;
  localparam int GW = 320, GH = 240;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_ready, busy, fb_we;
  logic [1:0] cmd_op = '0;
  logic [8:0] cmd_x0 = '0, cmd_x1 = '0;
  logic [7:0] cmd_y0 = '0, cmd_y1 = '0;
  logic [3:0] cmd_pal = '0, fb_pal;
  logic [9:0] fb_xloc;
  logic [8:0] fb_yloc;
  int n_cmp = 0, n_bad = 0;
  int q_we[$], q_x[$], q_y[$];

  graph_draw_engine #(.GW(GW), .GH(GH)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1), .cmd_pal(cmd_pal),
    .busy(busy), .fb_we(fb_we), .fb_xloc(fb_xloc), .fb_yloc(fb_yloc), .fb_pal(fb_pal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int x, input int y, input bit on);
    q_we.push_back((on && x < GW && y < GH) ? 1 : 0);
    q_x.push_back(2 * x);
    q_y.push_back(2 * y);
  endtask

  // Pixel list the command should produce, one entry per busy cycle
  task automatic model(input int op, input int x0, input int y0, input int x1, input int y1);
    int dx, dy, sx, sy, err, e2, x, y;
    q_we.delete(); q_x.delete(); q_y.delete();
    if (op == 0) push(x0, y0, 1);
    else if (op == 3) push(0, 0, 0);
    else if (op == 2) begin
      for (int j = 0; j < GH; j++) for (int i = 0; i < GW; i++) push(i, j, 1);
    end else begin
      dx = x1 > x0 ? x1 - x0 : x0 - x1;
      dy = y1 > y0 ? y0 - y1 : y1 - y0;
      sx = x0 < x1 ? 1 : -1;
      sy = y0 < y1 ? 1 : -1;
      err = dx + dy; x = x0; y = y0;
      forever begin
        push(x, y, 1);
        if (x == x1 && y == y1) break;
        e2 = 2 * err;
        if (e2 >= dy) begin err += dy; x += sx; end
        if (e2 <= dx) begin err += dx; y += sy; end
      end
    end
  endtask

  task automatic run_cmd(input string tag, input int op, input int x0, input int y0,
                         input int x1, input int y1, input int pal);
    int n, dx, dy;
    model(op, x0, y0, x1, y1);
    cmd_op = 2'(op); cmd_x0 = 9'(x0); cmd_y0 = 8'(y0); cmd_x1 = 9'(x1); cmd_y1 = 8'(y1);
    cmd_pal = 4'(pal); cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_x0 = 9'($urandom); cmd_y0 = 8'($urandom); cmd_x1 = 9'($urandom);
    cmd_y1 = 8'($urandom); cmd_pal = 4'($urandom); cmd_op = 2'($urandom);
    n = 0;
    while (!cmd_ready && n < 100000) begin
      if (n < q_we.size()) begin
        chk({tag, "_we"}, 32'(fb_we), 32'(q_we[n]));
        if (q_we[n] == 1) begin
          chk({tag, "_x"}, 32'(fb_xloc), 32'(q_x[n]));
          chk({tag, "_y"}, 32'(fb_yloc), 32'(q_y[n]));
          chk({tag, "_pal"}, 32'(fb_pal), 32'(pal));
        end
      end
      n++;
      @(posedge clk); #1;
    end
    chk({tag, "_cycles"}, 32'(n), 32'(q_we.size()));
    if (op == 1) begin
      dx = x1 > x0 ? x1 - x0 : x0 - x1;
      dy = y1 > y0 ? y1 - y0 : y0 - y1;
      chk({tag, "_len"}, 32'(n), 32'((dx > dy ? dx : dy) + 1));
    end
    chk({tag, "_idle_we"}, 32'(fb_we), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_we", 32'(fb_we), 32'd0);
    chk("rst_x", 32'(fb_xloc), 32'd0);
    chk("rst_y", 32'(fb_yloc), 32'd0);
    chk("rst_pal", 32'(fb_pal), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    run_cmd("plot", 0, 10, 20, 0, 0, 5);
    run_cmd("hline", 1, 0, 0, 3, 0, 10);
    run_cmd("steep", 1, 5, 9, 3, 2, 7);
    run_cmd("clip_plot", 0, 320, 0, 0, 0, 3);
    run_cmd("clip_line", 1, 318, 0, 321, 0, 9);
    run_cmd("dot_line", 1, 100, 50, 100, 50, 2);
    run_cmd("reserved", 3, 1, 1, 2, 2, 4);
    run_cmd("corner", 1, 511, 255, 0, 0, 15);
    for (int k = 0; k < 20; k++)
      run_cmd("rand", $urandom_range(0, 3) == 0 ? 0 : ($urandom_range(0, 5) == 0 ? 3 : 1),
              $urandom_range(0, 511), $urandom_range(0, 255),
              $urandom_range(0, 511), $urandom_range(0, 255), $urandom_range(0, 15));
    // rst asserted together with a valid command must win
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd0; cmd_x0 = 9'd10; cmd_y0 = 8'd10;
    @(posedge clk); #1;
    rst = 1'b0; cmd_valid = 1'b0;
    chk("prio_ready", 32'(cmd_ready), 32'd1);
    chk("prio_we", 32'(fb_we), 32'd0);
    // reset during the third write of a long line
    cmd_op = 2'd1; cmd_x0 = 9'd0; cmd_y0 = 8'd0; cmd_x1 = 9'd50; cmd_y1 = 8'd0;
    cmd_pal = 4'd6; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("abort_w1", 32'(fb_xloc), 32'd0);
    @(posedge clk); #1;
    chk("abort_w2", 32'(fb_xloc), 32'd2);
    @(posedge clk); #1;
    chk("abort_w3", 32'(fb_xloc), 32'd4);
    chk("abort_w3_we", 32'(fb_we), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk("abort_xloc", 32'(fb_xloc), 32'd0);
    for (int k = 0; k < 5; k++) begin
      chk("abort_we", 32'(fb_we), 32'd0);
      @(posedge clk); #1;
    end
    run_cmd("post_abort", 0, 10, 20, 0, 0, 5);
    run_cmd("clear", 2, 0, 0, 0, 0, 0);
    run_cmd("after_clear", 1, 7, 3, 0, 9, 12);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/graph_draw_engine.md
GRAPH_DRAW_ENGINE -- requirements
Module: graph_draw_engine

Interface
REQ-001 SHALL have parameter GW, default 320, meaning graph width in logical pixels.
REQ-002 SHALL have parameter GH, default 240, meaning graph height in logical pixels.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port cmd_valid, input, 1 bit: command present.
REQ-006 SHALL have port cmd_ready, output, 1 bit: engine can accept a command.
REQ-007 SHALL have port cmd_op, input, 2 bits: 00 PLOT, 01 LINE, 10 CLEAR, 11 reserved.
REQ-008 SHALL have ports cmd_x0 and cmd_x1, input, 9 bits each: logical x start and end.
REQ-009 SHALL have ports cmd_y0 and cmd_y1, input, 8 bits each: logical y start and end.
REQ-010 SHALL have port cmd_pal, input, 4 bits: palette index to write.
REQ-011 SHALL have port busy, output, 1 bit: command in progress.
REQ-012 SHALL have port fb_we, output, 1 bit: framebuffer write enable.
REQ-013 SHALL have port fb_xloc, output, 10 bits: screen x, equal to logical x times 2.
REQ-014 SHALL have port fb_yloc, output, 9 bits: screen y, equal to logical y times 2.
REQ-015 SHALL have port fb_pal, output, 4 bits: write color.

Function
REQ-016 SHALL use FSM states IDLE, PLOT, LINE, CLEAR.
REQ-017 SHALL drive cmd_ready=1 only in IDLE, and busy = NOT cmd_ready.
REQ-018 SHALL accept a command on any rising edge where cmd_valid and cmd_ready are both 1, latching all cmd_* fields.
REQ-019 SHALL leave cmd_* fields ignored while busy.
REQ-020 SHALL register all fb_* outputs.
REQ-021 SHALL present the first write of an accepted command in the cycle immediately following the acceptance edge (latency 1).
REQ-022 SHALL perform PLOT as exactly one write cycle at (x0,y0), then return to IDLE, with cmd_ready=1 on the following cycle.
REQ-023 SHALL perform LINE with the Bresenham algorithm from (x0,y0) to (x1,y1) inclusive, all octants, writing one pixel per cycle.
REQ-024 SHALL make a LINE take exactly max(|dx|,|dy|)+1 write cycles.
REQ-025 SHALL use a signed error term of at least 11 bits for LINE, with no overflow for any 9-bit/8-bit endpoints.
REQ-026 SHALL treat a LINE with equal endpoints as a single write, identical to PLOT.
REQ-027 SHALL perform CLEAR as a raster scan: x from 0 to GW-1 inner, y from 0 to GH-1 outer, one write per cycle, GW*GH cycles in total, then return to IDLE.
REQ-028 SHALL clip: any pixel with x>=GW or y>=GH holds fb_we=0 for its cycle.
REQ-029 SHALL spend a cycle on every clipped pixel, so clipping does not change command duration.
REQ-030 SHALL accept op 11 and return to IDLE after one cycle with no writes.
REQ-031 SHALL set fb_pal to the latched cmd_pal on every write cycle.
REQ-032 SHALL hold fb_we=0 in IDLE; fb_xloc, fb_yloc and fb_pal then hold their last values.
REQ-033 SHALL allow back-to-back commands: a new command can be accepted on the first IDLE cycle, with no extra dead cycle.

Reset
REQ-034 SHALL, on any rising edge with rst=1, enter IDLE and set fb_we=0, fb_xloc=0, fb_yloc=0, fb_pal=0 and busy=0, with cmd_ready=1 from the next cycle.
REQ-035 SHALL, on reset during PLOT, LINE or CLEAR, abort the operation with no further writes and discard the command.
REQ-036 SHALL give rst priority over command acceptance in the same cycle.

Verification
REQ-037 SHALL verify PLOT: x0=10, y0=20, pal=5 -> exactly one fb_we pulse, one cycle after acceptance, with xloc=20, yloc=40, pal=5.
REQ-038 SHALL verify horizontal LINE: (0,0)->(3,0), pal=A -> 4 consecutive writes at xloc 0, 2, 4, 6 with yloc=0, then cmd_ready=1.
REQ-039 SHALL verify steep reverse LINE: (5,9)->(3,2) -> 8 writes; y goes 9 down to 2; first write (10,18), last write (6,4).
REQ-040 SHALL verify clipping: PLOT (320,0) -> no fb_we, busy for 1 cycle; LINE (318,0)->(321,0) -> 4 cycles, writes only at xloc 636 and 638.
REQ-041 SHALL verify CLEAR, pal=0 -> 76800 writes; first write (0,0), last write (638,478); cmd_ready=1 on the next cycle.
REQ-042 SHALL verify reset mid-operation: rst pulsed in the 3rd write cycle of LINE (0,0)->(50,0) -> no fb_we afterwards, IDLE, cmd_ready=1; a following PLOT executes normally.
